frame_uart_dumper: RTL and testbench



---
 rtl/frame_dump_pkg.sv | 26 ++
 rtl/uart_byte_tx.sv | 65 ++++++
 rtl/frame_uart_dumper.sv | 173 +++++++++++++++++
 tb/tb_frame_uart_dumper.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_dump_pkg.sv
// Shared definitions for the frame UART dumper: stream header bytes,
// the dump sequencer state type and a helper that sizes the pixel counter.
package frame_dump_pkg;

    // Two fixed sync bytes that open every dumped frame
    localparam logic [7:0] HDR0 = 8'hAA;
    localparam logic [7:0] HDR1 = 8'h55;

    // Dump sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_FETCH,
        ST_SEND,
        ST_CSUM,
        ST_DONE
    } dump_state_t;

    // Pixel counter width: one bit of headroom above the frame size so the
    // index never wraps inside a frame
    function automatic int pixCntWidth(input int imgW, input int imgH);
        return $clog2(imgW * imgH) + 1;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte transmitter, LSB first. A byte is accepted when valid_in is high
// while the transmitter is idle; the start bit appears on the line one cycle
// after acceptance and busy_out drops on the cycle the stop bit ends.
module uart_byte_tx #(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       busy_out,
    output logic       txd_out
);

    localparam int BAUD_W = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

    logic              r_busy;
    logic              r_load;
    logic              r_txd;
    logic [9:0]        r_shift;
    logic [BAUD_W-1:0] r_baudCnt;
    logic [3:0]        r_bitCnt;

    // Accept a byte, spend one cycle loading the frame, then shift out start,
    // data and stop bits, each held for BAUD_DIV cycles
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy    <= 1'b0;
            r_load    <= 1'b0;
            r_txd     <= 1'b1;
            r_shift   <= '1;
            r_baudCnt <= '0;
            r_bitCnt  <= '0;
        end else if (!r_busy) begin
            if (valid_in) begin
                r_busy  <= 1'b1;
                r_load  <= 1'b1;
                r_shift <= {1'b1, data_in, 1'b0};
            end
        end else if (r_load) begin
            r_load    <= 1'b0;
            r_txd     <= r_shift[0];
            r_shift   <= {1'b1, r_shift[9:1]};
            r_baudCnt <= '0;
            r_bitCnt  <= '0;
        end else if (r_baudCnt == BAUD_LAST) begin
            r_baudCnt <= '0;
            if (r_bitCnt == 4'd9) begin
                r_busy <= 1'b0;
                r_txd  <= 1'b1;
            end else begin
                r_bitCnt <= r_bitCnt + 4'd1;
                r_txd    <= r_shift[0];
                r_shift  <= {1'b1, r_shift[9:1]};
            end
        end else begin
            r_baudCnt <= r_baudCnt + BAUD_W'(1);
        end
    end

    assign busy_out = r_busy;
    assign txd_out  = r_txd;

endmodule

// File: rtl/frame_uart_dumper.sv
// Streams one stored frame from the frame BRAM out of the UART pin as
// 0xAA 0x55, IMG_W*IMG_H pixel bytes in address order, then an 8-bit
// checksum of the pixel bytes. The BRAM is read one pixel at a time with a
// fixed read latency; throughput is set by the UART, so no prefetch is done.
module frame_uart_dumper #(
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int ADDR_W   = 17,
    parameter int BAUD_DIV = 868,
    parameter int RAM_LAT  = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    output logic [ADDR_W-1:0] rd_addr_out,
    input  logic [7:0]        rd_data_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              uart_txd_out
);

    import frame_dump_pkg::*;

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int CNT_W = pixCntWidth(IMG_W, IMG_H);
    localparam int LAT_W = (RAM_LAT < 2) ? 1 : $clog2(RAM_LAT + 1);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);
    localparam logic [LAT_W-1:0] LAT_DONE = LAT_W'(RAM_LAT);

    dump_state_t       r_state;
    dump_state_t       w_nextState;
    logic [CNT_W-1:0]  r_index;
    logic [CNT_W-1:0]  w_indexNext;
    logic [ADDR_W-1:0] r_rdAddr;
    logic [7:0]        r_csum;
    logic [LAT_W-1:0]  r_latCnt;
    logic              r_sent;
    logic [7:0]        w_txData;
    logic              w_txValid;
    logic              w_txBusy;
    logic              w_txd;

    assign w_indexNext = r_index + CNT_W'(1);

    // State register; reset aborts any frame in progress immediately
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and byte handoff to the transmitter. A pixel is handed over
    // in the same cycle its read data becomes valid, which keeps the gap
    // between consecutive bytes as short as the read latency allows.
    always_comb begin
        w_nextState = r_state;
        w_txValid   = 1'b0;
        w_txData    = HDR0;
        unique case (r_state)
            ST_IDLE: begin
                if (start_in) begin
                    w_nextState = ST_HDR0;
                end
            end
            ST_HDR0: begin
                w_txData  = HDR0;
                w_txValid = !r_sent;
                if (r_sent && !w_txBusy) begin
                    w_nextState = ST_HDR1;
                end
            end
            ST_HDR1: begin
                w_txData  = HDR1;
                w_txValid = !r_sent;
                if (r_sent && !w_txBusy) begin
                    w_nextState = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_txData = rd_data_in;
                if (r_latCnt == LAT_DONE && !w_txBusy) begin
                    w_txValid   = 1'b1;
                    w_nextState = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!w_txBusy) begin
                    w_nextState = (r_index == LAST_PIX) ? ST_CSUM : ST_FETCH;
                end
            end
            ST_CSUM: begin
                w_txData  = r_csum;
                w_txValid = !r_sent;
                if (r_sent && !w_txBusy) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Datapath: pixel index, read address, latency wait, checksum and the
    // flag that remembers a header/checksum byte has already been handed off
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_index  <= '0;
            r_rdAddr <= '0;
            r_csum   <= '0;
            r_latCnt <= '0;
            r_sent   <= 1'b0;
        end else begin
            if (w_nextState != r_state) begin
                r_sent <= 1'b0;
            end else if (w_txValid && !w_txBusy) begin
                r_sent <= 1'b1;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (start_in) begin
                        r_index <= '0;
                        r_csum  <= '0;
                    end
                end
                ST_HDR1: begin
                    if (w_nextState == ST_FETCH) begin
                        r_rdAddr <= ADDR_W'(r_index);
                        r_latCnt <= '0;
                    end
                end
                ST_FETCH: begin
                    if (r_latCnt != LAT_DONE) begin
                        r_latCnt <= r_latCnt + LAT_W'(1);
                    end else if (!w_txBusy) begin
                        r_csum <= r_csum + rd_data_in;
                    end
                end
                ST_SEND: begin
                    if (w_nextState == ST_FETCH) begin
                        r_index  <= w_indexNext;
                        r_rdAddr <= ADDR_W'(w_indexNext);
                        r_latCnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    uart_byte_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .data_in  (w_txData),
        .valid_in (w_txValid),
        .busy_out (w_txBusy),
        .txd_out  (w_txd)
    );

    assign rd_addr_out  = r_rdAddr;
    assign busy_out     = (r_state != ST_IDLE);
    assign done_out     = (r_state == ST_DONE);
    assign uart_txd_out = w_txd;

endmodule

// File: tb/tb_frame_uart_dumper.sv
// Self-checking bench for frame_uart_dumper on a tiny 4x2 frame with a fast
// baud divider. A behavioural BRAM with two register stages feeds the DUT;
// the TX line is logged per cycle and decoded into bytes, which are compared
// with the frame expected from the RAM contents.
module tb_frame_uart_dumper;

    localparam int IMG_W    = 4;
    localparam int IMG_H    = 2;
    localparam int NPIX     = IMG_W * IMG_H;
    localparam int ADDR_W   = 17;
    localparam int BAUD_DIV = 4;
    localparam int RAM_LAT  = 2;
    localparam int MAX_GAP  = 1 + RAM_LAT + 2;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] rdAddr;
    logic [7:0]        rdData;
    logic              busy;
    logic              done;
    logic              txd;

    int nCmp  = 0;
    int nFail = 0;
    int cyc   = 0;

    int         ramMode;
    logic [7:0] ramTable [NPIX];
    logic [7:0] ramPipe;

    bit         capture;
    bit         txLog[$];
    int         cycLog[$];
    int         addrLog[$];
    int         runLog[$];
    int         doneCount;
    int         busyDoneErr;
    int         maxAddr;
    int         prevAddr;
    int         addrRun;
    int         startCyc;

    logic [7:0] expBytes[$];
    logic [7:0] rxBytes[$];
    int         byteErr;
    int         frameErr;
    int         maxGap;
    int         addrErr;
    int         firstLat;

    frame_uart_dumper #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .ADDR_W   (ADDR_W),
        .BAUD_DIV (BAUD_DIV),
        .RAM_LAT  (RAM_LAT)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .start_in     (start),
        .rd_addr_out  (rdAddr),
        .rd_data_in   (rdData),
        .busy_out     (busy),
        .done_out     (done),
        .uart_txd_out (txd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // RAM contents as a function of address for the current test mode
    function automatic logic [7:0] ramValue(input int a);
        case (ramMode)
            0:       return a[7:0];
            1:       return 8'hFF;
            default: return ramTable[a % NPIX];
        endcase
    endfunction

    // Behavioural BRAM: data appears two clocks after the address
    always @(posedge clk) begin
        ramPipe <= ramValue(int'(rdAddr));
        rdData  <= ramPipe;
    end

    // Per-cycle logger for TX line, read address and done pulses
    initial begin
        forever begin
            @(negedge clk);
            if (capture) begin
                if (int'(rdAddr) == prevAddr) addrRun++;
                else addrRun = 1;
                prevAddr = int'(rdAddr);
                if (prevAddr > maxAddr) maxAddr = prevAddr;
                txLog.push_back(txd);
                cycLog.push_back(cyc);
                addrLog.push_back(prevAddr);
                runLog.push_back(addrRun);
                if (done) begin
                    doneCount++;
                    if (busy !== 1'b1) busyDoneErr++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clearLog();
        txLog.delete();
        cycLog.delete();
        addrLog.delete();
        runLog.delete();
        doneCount   = 0;
        busyDoneErr = 0;
        maxAddr     = 0;
        prevAddr    = int'(rdAddr);
        addrRun     = 0;
    endtask

    task automatic buildExpected();
        logic [7:0] sum;
        sum = 8'h00;
        expBytes.delete();
        expBytes.push_back(8'hAA);
        expBytes.push_back(8'h55);
        for (int p = 0; p < NPIX; p++) begin
            expBytes.push_back(ramValue(p));
            sum = sum + ramValue(p);
        end
        expBytes.push_back(sum);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 startCyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, output bit timedOut);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        timedOut = (n >= budget);
    endtask

    // Decode the logged line into bytes and derive timing/address metrics
    task automatic analyseLog();
        int i;
        int lastEnd;
        int firstIdx;
        int sz;
        logic [7:0] b;
        rxBytes.delete();
        frameErr = 0;
        maxGap   = 0;
        addrErr  = 0;
        byteErr  = 0;
        firstIdx = -1;
        lastEnd  = -1;
        sz       = txLog.size();
        i        = 0;
        while (i < sz) begin
            if (txLog[i] == 1'b0) begin
                if (firstIdx < 0) firstIdx = i;
                if (lastEnd >= 0 && (i - lastEnd) > maxGap) maxGap = i - lastEnd;
                b = 8'h00;
                for (int bitN = 0; bitN < 10; bitN++) begin
                    for (int j = 0; j < BAUD_DIV; j++) begin
                        if (i + bitN * BAUD_DIV + j >= sz) frameErr++;
                        else if (txLog[i + bitN * BAUD_DIV + j] != txLog[i + bitN * BAUD_DIV]) frameErr++;
                    end
                end
                if (i + 9 * BAUD_DIV >= sz || txLog[i + 9 * BAUD_DIV] != 1'b1) frameErr++;
                for (int k = 0; k < 8; k++) begin
                    if (i + (k + 1) * BAUD_DIV < sz) b[k] = txLog[i + (k + 1) * BAUD_DIV];
                end
                if (rxBytes.size() >= 2 && rxBytes.size() < 2 + NPIX) begin
                    if (addrLog[i] != rxBytes.size() - 2 || runLog[i] < RAM_LAT + 1) addrErr++;
                end
                rxBytes.push_back(b);
                lastEnd = i + 10 * BAUD_DIV;
                i = lastEnd;
            end else begin
                i++;
            end
        end
        for (int k = 0; k < rxBytes.size() && k < expBytes.size(); k++) begin
            if (rxBytes[k] !== expBytes[k]) byteErr++;
        end
        firstLat = (firstIdx >= 0) ? cycLog[firstIdx] - startCyc : -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        nCmp++; if (txd !== 1'b1) begin nFail++; $display("[TB] FAIL reset_txd got=%b want=1", txd); end
        nCmp++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        nCmp++; if (done !== 1'b0) begin nFail++; $display("[TB] FAIL reset_done got=%b want=0", done); end
        nCmp++; if (rdAddr !== '0) begin nFail++; $display("[TB] FAIL reset_addr got=%0d want=0", rdAddr); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame(input int mode, input string tag);
        bit timedOut;
        logic [7:0] wantCs;
        logic [7:0] gotCs;
        ramMode = mode;
        if (mode == 2) begin
            for (int p = 0; p < NPIX; p++) ramTable[p] = 8'($urandom_range(0, 255));
        end
        buildExpected();
        repeat ($urandom_range(1, 5)) @(negedge clk);
        clearLog();
        capture = 1'b1;
        repeat (3) @(negedge clk);
        pulseStart();
        waitDone(3000, timedOut);
        repeat (30) @(negedge clk);
        capture = 1'b0;
        analyseLog();
        if (mode == 0) wantCs = 8'h1C;
        else if (mode == 1) wantCs = 8'hF8;
        else wantCs = expBytes[NPIX + 2];
        gotCs = (rxBytes.size() > NPIX + 2) ? rxBytes[NPIX + 2] : 8'hxx;
        nCmp++; if (timedOut) begin nFail++; $display("[TB] FAIL %s done_timeout got=timeout want=done", tag); end
        nCmp++; if (rxBytes.size() !== NPIX + 3) begin nFail++; $display("[TB] FAIL %s byte_count got=%0d want=%0d", tag, rxBytes.size(), NPIX + 3); end
        nCmp++; if (byteErr !== 0) begin nFail++; $display("[TB] FAIL %s byte_values got=%0d_wrong want=0_wrong", tag, byteErr); end
        nCmp++; if (gotCs !== wantCs) begin nFail++; $display("[TB] FAIL %s checksum got=%h want=%h", tag, gotCs, wantCs); end
        nCmp++; if (frameErr !== 0) begin nFail++; $display("[TB] FAIL %s bit_timing got=%0d_errors want=0", tag, frameErr); end
        nCmp++; if (!(maxGap <= MAX_GAP)) begin nFail++; $display("[TB] FAIL %s byte_gap got=%0d want<=%0d", tag, maxGap, MAX_GAP); end
        nCmp++; if (firstLat !== 2) begin nFail++; $display("[TB] FAIL %s start_latency got=%0d want=2", tag, firstLat); end
        nCmp++; if (addrErr !== 0) begin nFail++; $display("[TB] FAIL %s addr_sequence got=%0d_errors want=0", tag, addrErr); end
        nCmp++; if (!(maxAddr <= NPIX - 1)) begin nFail++; $display("[TB] FAIL %s addr_max got=%0d want<=%0d", tag, maxAddr, NPIX - 1); end
        nCmp++; if (doneCount !== 1) begin nFail++; $display("[TB] FAIL %s done_pulses got=%0d want=1", tag, doneCount); end
        nCmp++; if (busyDoneErr !== 0) begin nFail++; $display("[TB] FAIL %s busy_at_done got=low want=high", tag); end
        nCmp++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL %s busy_after got=%b want=0", tag, busy); end
        nCmp++; if (txLog.size() == 0 || txLog[0] !== 1'b1) begin nFail++; $display("[TB] FAIL %s idle_before got=low want=1", tag); end
        nCmp++; if (txd !== 1'b1) begin nFail++; $display("[TB] FAIL %s idle_after got=%b want=1", tag, txd); end
    endtask

    task automatic test_start_spam();
        bit timedOut;
        ramMode = 2;
        for (int p = 0; p < NPIX; p++) ramTable[p] = 8'($urandom_range(0, 255));
        buildExpected();
        clearLog();
        capture = 1'b1;
        repeat (3) @(negedge clk);
        pulseStart();
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(20, 60)) @(negedge clk);
            pulseStart();
        end
        waitDone(3000, timedOut);
        repeat (600) @(negedge clk);
        capture = 1'b0;
        analyseLog();
        nCmp++; if (timedOut) begin nFail++; $display("[TB] FAIL spam done_timeout got=timeout want=done"); end
        nCmp++; if (rxBytes.size() !== NPIX + 3) begin nFail++; $display("[TB] FAIL spam byte_count got=%0d want=%0d", rxBytes.size(), NPIX + 3); end
        nCmp++; if (byteErr !== 0) begin nFail++; $display("[TB] FAIL spam byte_values got=%0d_wrong want=0_wrong", byteErr); end
        nCmp++; if (doneCount !== 1) begin nFail++; $display("[TB] FAIL spam done_pulses got=%0d want=1", doneCount); end
        nCmp++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL spam busy_after got=%b want=0", busy); end
    endtask

    task automatic test_reset_midframe();
        int n;
        ramMode = 0;
        clearLog();
        capture = 1'b1;
        pulseStart();
        n = 0;
        while (rdAddr !== 3 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        nCmp++; if (n >= 3000) begin nFail++; $display("[TB] FAIL abort reach_pixel3 got=timeout want=addr3"); end
        repeat (20) @(negedge clk);
        n = 0;
        while (txd !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        nCmp++; if (txd !== 1'b0) begin nFail++; $display("[TB] FAIL abort pre_reset_txd got=%b want=0", txd); end
        #2 rst = 1'b1;
        #1;
        nCmp++; if (txd !== 1'b1) begin nFail++; $display("[TB] FAIL abort async_txd got=%b want=1", txd); end
        nCmp++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL abort async_busy got=%b want=0", busy); end
        nCmp++; if (done !== 1'b0) begin nFail++; $display("[TB] FAIL abort async_done got=%b want=0", done); end
        nCmp++; if (rdAddr !== '0) begin nFail++; $display("[TB] FAIL abort async_addr got=%0d want=0", rdAddr); end
        capture = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_frame(2, "after_reset");
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        capture = 1'b0;
        ramMode = 0;
        for (int p = 0; p < NPIX; p++) ramTable[p] = 8'h00;
        test_reset();
        test_frame(0, "addr_pattern");
        test_frame(1, "all_ff");
        test_frame(2, "random_a");
        test_frame(2, "random_b");
        test_start_spam();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
